instr_fetch: RTL and testbench

INSTR_FETCH -- requirements
Module: instr_fetch

---
 rtl/instr_fetch.sv | 169 ++++++++++++++++
 tb/tb_instr_fetch.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch.sv
// Instruction fetch unit: in-order memory requests, 2-entry fetch buffer, redirect flush with response dropping.
// Optional macro IFETCH_MISALIGN_TRAP_EN: a misaligned redirect target halts fetch instead of being masked.
module instr_fetch #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        stall,
    output logic [31:0] instruction,
    output logic [31:0] instr_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic        misaligned
);

    localparam int unsigned XLEN  = 32;
    localparam int unsigned CNT_W = 2;
    localparam int unsigned SUM_W = 3;

    logic [XLEN-1:0]  fetch_pc_q, fetch_pc_d;
    logic [CNT_W-1:0] outstanding_q, outstanding_d;
    logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;
    logic [CNT_W-1:0] fifo_cnt_q, fifo_cnt_d;

    logic [XLEN-1:0]  tag_q [2];
    logic [XLEN-1:0]  tag_d [2];
    logic             tag_wr_q, tag_wr_d, tag_rd_q, tag_rd_d;

    logic [XLEN-1:0]  fpc_q [2];
    logic [XLEN-1:0]  fpc_d [2];
    logic [XLEN-1:0]  fdata_q [2];
    logic [XLEN-1:0]  fdata_d [2];
    logic             f_wr_q, f_wr_d, f_rd_q, f_rd_d;

    logic [XLEN-1:0]  redir_target_c;
    logic             halted_c;
    logic [SUM_W-1:0] inflight_c;
    logic             req_fire_c;
    logic             rsp_c;
    logic             rsp_keep_c;
    logic             pop_c;

`ifdef IFETCH_MISALIGN_TRAP_EN
    logic halted_q, halted_d, misaligned_q, misaligned_d;
    logic redir_misaligned_c;

    assign redir_target_c     = redirect_pc;
    assign redir_misaligned_c = |redirect_pc[1:0];
    assign halted_c           = halted_q;
    assign misaligned         = misaligned_q;

    // Any redirect re-evaluates the trap: misaligned target halts, aligned target resumes.
    always_comb begin
        halted_d     = halted_q;
        misaligned_d = misaligned_q;
        if (redirect_valid) begin
            halted_d     = redir_misaligned_c;
            misaligned_d = redir_misaligned_c;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            halted_q     <= 1'b0;
            misaligned_q <= 1'b0;
        end else begin
            halted_q     <= halted_d;
            misaligned_q <= misaligned_d;
        end
    end
`else
    assign redir_target_c = redirect_pc & ~32'h0000_0003;
    assign halted_c       = 1'b0;
    assign misaligned     = 1'b0;
`endif

    // Dropped (pre-redirect) requests stay in outstanding until their responses return.
    assign inflight_c     = SUM_W'(outstanding_q) + SUM_W'(fifo_cnt_q);
    assign imem_req_valid = ~rst & ~halted_c & ~redirect_valid & (inflight_c < SUM_W'(FIFO_DEPTH));
    assign imem_addr      = fetch_pc_q;
    assign req_fire_c     = imem_req_valid & imem_req_ready;
    assign rsp_c          = imem_rsp_valid & ~rst;
    assign rsp_keep_c     = rsp_c & ~redirect_valid & (drop_cnt_q == '0);

    assign instr_valid    = ~rst & (fifo_cnt_q != '0) & ~stall;
    assign instruction    = fdata_q[f_rd_q];
    assign instr_pc       = fpc_q[f_rd_q];
    assign pop_c          = instr_valid & instr_ready;

    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        outstanding_d = outstanding_q + CNT_W'(req_fire_c) - CNT_W'(rsp_c);
        drop_cnt_d    = drop_cnt_q;
        fifo_cnt_d    = fifo_cnt_q + CNT_W'(rsp_keep_c) - CNT_W'(pop_c);
        tag_d         = tag_q;
        tag_wr_d      = tag_wr_q;
        tag_rd_d      = tag_rd_q;
        fpc_d         = fpc_q;
        fdata_d       = fdata_q;
        f_wr_d        = f_wr_q;
        f_rd_d        = f_rd_q;

        if (req_fire_c) begin
            fetch_pc_d       = fetch_pc_q + XLEN'(4);
            tag_d[tag_wr_q]  = fetch_pc_q;
            tag_wr_d         = ~tag_wr_q;
        end
        if (rsp_c && !redirect_valid && drop_cnt_q != '0) begin
            drop_cnt_d = drop_cnt_q - CNT_W'(1);
        end
        if (rsp_keep_c) begin
            fpc_d[f_wr_q]   = tag_q[tag_rd_q];
            fdata_d[f_wr_q] = imem_rsp_data;
            f_wr_d          = ~f_wr_q;
            tag_rd_d        = ~tag_rd_q;
        end
        if (pop_c) begin
            f_rd_d = ~f_rd_q;
        end

        // Redirect wins: everything still in flight after this cycle becomes a drop.
        if (redirect_valid) begin
            fetch_pc_d = redir_target_c;
            drop_cnt_d = outstanding_d;
            fifo_cnt_d = '0;
            tag_wr_d   = 1'b0;
            tag_rd_d   = 1'b0;
            f_wr_d     = 1'b0;
            f_rd_d     = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc_q    <= RESET_PC;
            outstanding_q <= '0;
            drop_cnt_q    <= '0;
            fifo_cnt_q    <= '0;
            tag_q         <= '{default: '0};
            tag_wr_q      <= 1'b0;
            tag_rd_q      <= 1'b0;
            fpc_q         <= '{default: '0};
            fdata_q       <= '{default: '0};
            f_wr_q        <= 1'b0;
            f_rd_q        <= 1'b0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            outstanding_q <= outstanding_d;
            drop_cnt_q    <= drop_cnt_d;
            fifo_cnt_q    <= fifo_cnt_d;
            tag_q         <= tag_d;
            tag_wr_q      <= tag_wr_d;
            tag_rd_q      <= tag_rd_d;
            fpc_q         <= fpc_d;
            fdata_q       <= fdata_d;
            f_wr_q        <= f_wr_d;
            f_rd_q        <= f_rd_d;
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
// Scoreboard bench for instr_fetch: in-order memory model, expected PCs queued at request
// acceptance and compared at each delivered instruction.
module tb_instr_fetch;

    localparam logic [31:0] RST_PC = 32'h0000_0000;

    logic        clk;
    logic        rst;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        stall;
    logic [31:0] instruction;
    logic [31:0] instr_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic        misaligned;

    instr_fetch #(.RESET_PC(RST_PC)) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_addr      (imem_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .stall          (stall),
        .instruction    (instruction),
        .instr_pc       (instr_pc),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .misaligned     (misaligned)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    int          mem_lat  = 1;
    bit          mem_hold = 1'b0;
    logic [31:0] mem_q [$];
    int          mem_t [$];
    logic [31:0] exp_q [$];
    logic [31:0] del_q [$];
    logic [31:0] m_pc;
    logic [31:0] mon_e;
    bit          m_halt;
    bit          redir_prev;
    int          issued = 0;
    int          base;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0] ^ 16'h5A3C, a[31:16] ^ 16'hC3A5};
    endfunction

    function automatic logic [31:0] tgt(input logic [31:0] p);
`ifdef IFETCH_MISALIGN_TRAP_EN
        return p;
`else
        return p & ~32'h0000_0003;
`endif
    endfunction

    function automatic logic [31:0] del_at(input int i);
        if (i < del_q.size()) return del_q[i];
        return 32'hDEAD_BEEF;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Memory: in-order responses mem_lat cycles after acceptance, flushed by the shared reset.
    initial begin
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (rst) begin
                mem_q.delete();
                mem_t.delete();
                imem_rsp_valid = 1'b0;
            end else if (!mem_hold && mem_q.size() != 0 && mem_t[0] <= cyc) begin
                imem_rsp_valid = 1'b1;
                imem_rsp_data  = mem_word(mem_q.pop_front());
                void'(mem_t.pop_front());
            end else begin
                imem_rsp_valid = 1'b0;
                imem_rsp_data  = '0;
            end
        end
    end

    // Monitor and scoreboard, sampled on the falling edge.
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                exp_q.delete();
                m_pc       = RST_PC;
                m_halt     = 1'b0;
                redir_prev = 1'b0;
            end else begin
                if (imem_req_valid && imem_req_ready) begin
                    mem_q.push_back(imem_addr);
                    mem_t.push_back(cyc + mem_lat);
                end
                if (redir_prev) check("valid_after_redirect", 32'(instr_valid), 32'd0);
                if (stall) check("valid_in_stall", 32'(instr_valid), 32'd0);
                if (instr_valid && instr_ready) begin
                    if (exp_q.size() == 0) begin
                        check("pop_unexpected", 32'(exp_q.size()), 32'd1);
                    end else begin
                        mon_e = exp_q.pop_front();
                        check("instr_pc", instr_pc, mon_e);
                        check("instruction", instruction, mem_word(mon_e));
                    end
                    del_q.push_back(instr_pc);
                end
                if (redirect_valid) begin
                    check("req_in_redirect", 32'(imem_req_valid), 32'd0);
                    exp_q.delete();
                    m_pc = tgt(redirect_pc);
`ifdef IFETCH_MISALIGN_TRAP_EN
                    m_halt = |redirect_pc[1:0];
`endif
                    redir_prev = 1'b1;
                end else begin
                    redir_prev = 1'b0;
                    if (m_halt) check("req_while_halted", 32'(imem_req_valid), 32'd0);
                    if (imem_req_valid && imem_req_ready) begin
                        check("imem_addr", imem_addr, m_pc);
                        exp_q.push_back(m_pc);
                        m_pc = m_pc + 32'd4;
                        issued++;
                    end
                end
            end
        end
    end

    task automatic do_reset();
        rst            = 1'b1;
        redirect_valid = 1'b0;
        tick();
        tick();
        check("rst_req_valid", 32'(imem_req_valid), 32'd0);
        check("rst_instr_valid", 32'(instr_valid), 32'd0);
        check("rst_instruction", instruction, 32'd0);
        check("rst_instr_pc", instr_pc, 32'd0);
        check("rst_misaligned", 32'(misaligned), 32'd0);
        rst = 1'b0;
        #1;
        check("first_req_valid", 32'(imem_req_valid), 32'd1);
        check("first_addr", imem_addr, RST_PC);
        del_q.delete();
        issued = 0;
    endtask

    task automatic redir(input logic [31:0] pc);
        redirect_pc    = pc;
        redirect_valid = 1'b1;
        tick();
        redirect_valid = 1'b0;
        del_q.delete();
    endtask

    task automatic wait_issued(input int n, input int budget);
        int k = 0;
        while (issued < n && k < budget) begin
            tick();
            k++;
        end
        check("wait_issued", 32'(issued), 32'(n));
    endtask

    initial begin
        rst            = 1'b1;
        imem_req_ready = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        stall          = 1'b0;
        instr_ready    = 1'b0;

        // Consumer blocked: two requests fill the buffer, then issue stops.
        do_reset();
        repeat (6) tick();
        check("block_issued", 32'(issued), 32'd2);
        check("block_req_valid", 32'(imem_req_valid), 32'd0);
        check("block_full_valid", 32'(instr_valid), 32'd1);
        instr_ready = 1'b1;
        repeat (10) tick();
        check("block_resumed", 32'(issued > 2), 32'd1);
        check("block_order0", del_at(0), 32'h0);
        check("block_order1", del_at(1), 32'h4);

        // Plain streaming from reset.
        do_reset();
        repeat (12) tick();
        check("stream_pc0", del_at(0), 32'h0);
        check("stream_pc1", del_at(1), 32'h4);
        check("stream_pc2", del_at(2), 32'h8);

        // Two requests (8, 12) in flight when redirected: both dropped.
        do_reset();
        wait_issued(2, 20);
        mem_hold = 1'b1;
        wait_issued(4, 20);
        tick();
        tick();
        check("drop_setup_issued", 32'(issued), 32'd4);
        check("drop_setup_req_valid", 32'(imem_req_valid), 32'd0);
        redir(32'h100);
        mem_hold = 1'b0;
        repeat (12) tick();
        check("drop_first_pc", del_at(0), 32'h100);

        // Response coincident with the redirect is discarded.
        do_reset();
        begin
            int k = 0;
            while (!imem_rsp_valid && k < 20) begin
                tick();
                k++;
            end
        end
        check("coinc_rsp_seen", 32'(imem_rsp_valid), 32'd1);
        redir(32'h40);
        repeat (8) tick();
        check("coinc_first_pc", del_at(0), 32'h40);

        // Stall holds the head while the buffer keeps filling.
        stall = 1'b1;
        redir(32'h10);
        base = issued;
        repeat (6) tick();
        check("stall_issued", 32'(issued - base), 32'd2);
        check("stall_valid", 32'(instr_valid), 32'd0);
        stall = 1'b0;
        repeat (6) tick();
        check("stall_first_pc", del_at(0), 32'h10);

        // Address wrap at the top of the address space.
        redir(32'hFFFF_FFF8);
        repeat (12) tick();
        check("wrap_pc0", del_at(0), 32'hFFFF_FFF8);
        check("wrap_pc1", del_at(1), 32'hFFFF_FFFC);
        check("wrap_pc2", del_at(2), 32'h0);

        // Misaligned redirect target.
`ifdef IFETCH_MISALIGN_TRAP_EN
        redir(32'h102);
        check("mis_flag_set", 32'(misaligned), 32'd1);
        base = issued;
        repeat (5) tick();
        check("mis_no_issue", 32'(issued - base), 32'd0);
        check("mis_req_valid", 32'(imem_req_valid), 32'd0);
        redir(32'h200);
        check("mis_flag_clear", 32'(misaligned), 32'd0);
        repeat (8) tick();
        check("mis_resume_pc", del_at(0), 32'h200);
`else
        redir(32'h102);
        repeat (8) tick();
        check("mis_flag_zero", 32'(misaligned), 32'd0);
        check("mis_masked_pc", del_at(0), 32'h100);
`endif

        // Randomised traffic: backpressure, stalls, latency changes and redirects.
        for (int i = 0; i < 400; i++) begin
            imem_req_ready = ($urandom_range(0, 3) != 0);
            instr_ready    = ($urandom_range(0, 3) != 0);
            stall          = ($urandom_range(0, 7) == 0);
            if (i % 50 == 0) mem_lat = $urandom_range(1, 3);
            if ($urandom_range(0, 19) == 0) begin
                redirect_pc = {16'h0, 16'($urandom)};
`ifdef IFETCH_MISALIGN_TRAP_EN
                redirect_pc = redirect_pc & ~32'h3;
`endif
                redirect_valid = 1'b1;
            end else begin
                redirect_valid = 1'b0;
            end
            tick();
        end
        redirect_valid = 1'b0;
        imem_req_ready = 1'b1;
        instr_ready    = 1'b1;
        stall          = 1'b0;
        mem_lat        = 2;
        repeat (5) tick();

        // Reset in the middle of traffic discards everything in flight.
        do_reset();
        mem_lat = 1;
        repeat (20) tick();
        check("midrst_first_pc", del_at(0), RST_PC);
        check("midrst_second_pc", del_at(1), RST_PC + 32'd4);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        n_fail++;
        $display("FAIL global_timeout got=%0t exp=<1000000", $time);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
